// File: rtl/wb_sram_slave_fsm.sv
// Wishbone classic slave that turns one decoded bus transaction into a single-cycle
// request to the core-SRAM steering mux, then acks on rvalid or on a bounded timeout.
module wb_sram_slave_fsm #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_E000,
  parameter int          TIMEOUT   = 16,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        sram_stb_o,
  output logic        sram_cyc_o,
  output logic        sram_we_o,
  output logic [3:0]  sram_be_o,
  output logic [10:0] sram_addr_o,
  output logic [31:0] sram_wdata_o,
  input  logic [31:0] sram_rdata_i,
  input  logic        sram_rvalid_i,
  output logic        busy_o,
  output logic        timeout_o,
  input  logic        timeout_clr_i
);

  // Handshake: a transaction is accepted when stb & cyc are high in IDLE with an
  // in-window address; the SRAM side sees stb/cyc for exactly one cycle (REQ) and
  // answers with one sram_rvalid_i pulse, for reads and writes alike.

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_ACK  = 2'd3;

  localparam int          CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          abort_q, abort_d;
  logic          timeout_q, timeout_d;
  logic          timeout_set;
  logic [31:0]   dat_q, dat_d;
  logic          we_q, we_d;
  logic [3:0]    be_q, be_d;
  logic [10:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          hit;

  assign hit     = wbs_stb_i & wbs_cyc_i & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    abort_d     = abort_q;
    dat_d       = dat_q;
    we_d        = we_q;
    be_d        = be_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    timeout_set = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (hit) begin
          addr_d  = wbs_adr_i[12:2];
          be_d    = wbs_sel_i;
          wdata_d = wbs_dat_i;
          we_d    = wbs_we_i;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        cnt_d = '0;
        if (!wbs_cyc_i) abort_d = 1'b1;
        if (sram_rvalid_i) begin
          if (!we_q) dat_d = sram_rdata_i;
          state_d = S_ACK;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        // The SRAM access cannot be cancelled, so an abort only suppresses the ack.
        if (!wbs_cyc_i) abort_d = 1'b1;
        if (sram_rvalid_i) begin
          if (!we_q) dat_d = sram_rdata_i;
          state_d = S_ACK;
        end else if (cnt_inc == CNT_LAST) begin
          if (!we_q) dat_d = ERR_DATA;
          timeout_set = 1'b1;
          state_d     = S_ACK;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_ACK: begin
        abort_d = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    timeout_d = timeout_q;
    if (timeout_set) begin
      timeout_d = 1'b1;
    end else if (timeout_clr_i) begin
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      abort_q   <= 1'b0;
      timeout_q <= 1'b0;
      dat_q     <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      abort_q   <= abort_d;
      timeout_q <= timeout_d;
      dat_q     <= dat_d;
      we_q      <= we_d;
      be_q      <= be_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign wbs_ack_o    = (state_q == S_ACK) && !abort_q;
  assign wbs_dat_o    = dat_q;
  assign sram_stb_o   = (state_q == S_REQ);
  assign sram_cyc_o   = (state_q == S_REQ);
  assign sram_we_o    = we_q;
  assign sram_be_o    = be_q;
  assign sram_addr_o  = addr_q;
  assign sram_wdata_o = wdata_q;
  assign busy_o       = (state_q != S_IDLE);
  assign timeout_o    = timeout_q;

endmodule
